// File: rtl/contador_presc_mod.sv
// Up/down counter with a programmable prescaler, live modulo limit, wrap/saturate select, load and terminal-count pulse.
// Latency: q and tc are registered (1 cycle); tick is combinational from pc and div. There is no backpressure: the block is always ready.
module contador_presc_mod #(
    parameter int P = 24,
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [P-1:0] div,
    input  logic [1:0]   s,
    input  logic         sat,
    input  logic [W-1:0] max,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         tick,
    output logic         tc
);

    localparam logic [1:0]   S_UP   = 2'd0;
    localparam logic [1:0]   S_DN   = 2'd1;
    localparam logic [1:0]   S_CLR  = 2'd3;
    localparam logic [P-1:0] PC_ONE = P'(1);
    localparam logic [W-1:0] Q_ONE  = W'(1);

    logic [P-1:0] pc_q, pc_d;
    logic [W-1:0] q_q, q_d;
    logic         tc_q, tc_d;

    // The >= compare (not ==) lets a lowered div end the current period at once.
    always_comb begin
        tick = (s != S_CLR) && (pc_q >= div);
    end

    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (s == S_CLR || tick) begin
            pc_d = '0;
        end
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (ld) begin
            q_d = (d > max) ? max : d;
        end else if (s == S_CLR) begin
            q_d = '0;
        end else if (tick) begin
            case (s)
                S_UP: begin
                    if (q_q < max) begin
                        q_d = q_q + Q_ONE;
                    end else begin
                        q_d  = sat ? max : '0;
                        tc_d = 1'b1;
                    end
                end
                S_DN: begin
                    if (q_q == '0) begin
                        q_d  = sat ? '0 : max;
                        tc_d = 1'b1;
                    end else if (q_q > max) begin
                        // max was lowered below the count: snap back into range silently
                        q_d = max;
                    end else begin
                        q_d = q_q - Q_ONE;
                    end
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q <= '0;
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_contador_presc_mod.sv
// Directed bench for contador_presc_mod: a driver queues hand-computed expectations, a monitor pops and compares each cycle.
module tb_contador_presc_mod;

    localparam int P = 24;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [P-1:0] div_i;
    logic [1:0]   s_i;
    logic         sat_i;
    logic [W-1:0] max_i;
    logic         ld_i;
    logic [W-1:0] d_i;
    logic [W-1:0] q_o;
    logic         tick_o;
    logic         tc_o;

    typedef struct {
        int           idx;
        logic [W-1:0] q;
        logic         tc;
        logic         tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;
    bit   stim_done = 1'b0;

    contador_presc_mod #(.P(P), .W(W)) dut (
        .CLK  (clk),
        .RST  (rst_n),
        .div  (div_i),
        .s    (s_i),
        .sat  (sat_i),
        .max  (max_i),
        .ld   (ld_i),
        .d    (d_i),
        .q    (q_o),
        .tick (tick_o),
        .tc   (tc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs 1 time unit after the edge and queue what must be
    // visible in that same cycle (q/tc from the edge just passed, tick from current inputs).
    task automatic v(input logic rst, input logic ld, input int d, input int s,
                     input logic sat, input int mx, input int dv,
                     input int eq, input logic etc, input logic etick);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        ld_i  = ld;
        d_i   = W'(d);
        s_i   = 2'(s);
        sat_i = sat;
        max_i = W'(mx);
        div_i = P'(dv);
        e.idx  = vec_n;
        e.q    = W'(eq);
        e.tc   = etc;
        e.tick = etick;
        exp_q.push_back(e);
        vec_n++;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #4;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (q_o !== e.q) begin
                errors++;
                $display("FAIL vec%0d q: got %0d expected %0d", e.idx, q_o, e.q);
            end
            checks++;
            if (tc_o !== e.tc) begin
                errors++;
                $display("FAIL vec%0d tc: got %b expected %b", e.idx, tc_o, e.tc);
            end
            checks++;
            if (tick_o !== e.tick) begin
                errors++;
                $display("FAIL vec%0d tick: got %b expected %b", e.idx, tick_o, e.tick);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ld_i  = 1'b0;
        d_i   = '0;
        s_i   = 2'd0;
        sat_i = 1'b0;
        max_i = 4'd9;
        div_i = '0;

        // Reset, then free-running wrap count 0..9 with div=0
        v(0, 0, 0, 0, 0, 9, 0,  0, 0, 1);
        v(1, 0, 0, 0, 0, 9, 0,  0, 0, 1);
        for (int i = 1; i <= 9; i++) v(1, 0, 0, 0, 0, 9, 0,  i, 0, 1);
        v(1, 0, 0, 0, 0, 9, 0,  0, 1, 1);
        v(1, 0, 0, 0, 0, 9, 0,  1, 0, 1);
        v(1, 0, 0, 0, 0, 9, 0,  2, 0, 1);

        // div=3: one step every 4 cycles, then div lowered below pc
        for (int k = 0; k < 2; k++) begin
            v(1, 0, 0, 0, 0, 15, 3,  3 + k, 0, 0);
            v(1, 0, 0, 0, 0, 15, 3,  3 + k, 0, 0);
            v(1, 0, 0, 0, 0, 15, 3,  3 + k, 0, 0);
            v(1, 0, 0, 0, 0, 15, 3,  3 + k, 0, 1);
        end
        v(1, 0, 0, 0, 0, 15, 3,  5, 0, 0);
        v(1, 0, 0, 0, 0, 15, 3,  5, 0, 0);
        v(1, 0, 0, 0, 0, 15, 1,  5, 0, 1);
        v(1, 0, 0, 0, 0, 15, 1,  6, 0, 0);
        v(1, 0, 0, 0, 0, 15, 1,  6, 0, 1);
        v(1, 0, 0, 0, 0, 15, 1,  7, 0, 0);
        v(1, 0, 0, 0, 0, 15, 1,  7, 0, 1);

        // Saturating up to max=5, then saturating down to 0
        v(1, 1, 4, 0, 1, 5, 0,  8, 0, 1);
        v(1, 0, 0, 0, 1, 5, 0,  4, 0, 1);
        v(1, 0, 0, 0, 1, 5, 0,  5, 0, 1);
        v(1, 0, 0, 0, 1, 5, 0,  5, 1, 1);
        v(1, 0, 0, 1, 1, 5, 0,  5, 1, 1);
        v(1, 0, 0, 1, 1, 5, 0,  4, 0, 1);
        v(1, 0, 0, 1, 1, 5, 0,  3, 0, 1);
        v(1, 0, 0, 1, 1, 5, 0,  2, 0, 1);
        v(1, 0, 0, 1, 1, 5, 0,  1, 0, 1);
        v(1, 0, 0, 1, 1, 5, 0,  0, 0, 1);
        v(1, 0, 0, 1, 1, 5, 0,  0, 1, 1);

        // Wrapping down from 0, clamped load, lowered max while counting down
        v(1, 0, 0, 1, 0, 7, 0,  0, 1, 1);
        v(1, 1, 12, 1, 0, 7, 0,  7, 1, 1);
        v(1, 0, 0, 2, 0, 7, 0,  7, 0, 1);
        v(1, 0, 0, 1, 0, 3, 0,  7, 0, 1);
        v(1, 0, 0, 2, 0, 3, 0,  3, 0, 1);
        v(1, 0, 0, 2, 0, 3, 0,  3, 0, 1);

        // Load beats clear; clear holds pc at 0; first step at edge div+1
        v(1, 1, 6, 3, 0, 7, 2,  3, 0, 0);
        v(1, 0, 0, 3, 0, 7, 2,  6, 0, 0);
        v(1, 0, 0, 3, 0, 7, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 1);
        v(1, 1, 5, 0, 0, 9, 2,  1, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  5, 0, 0);

        // Asynchronous reset between edges at q=5, then restart from pc=0
        v(0, 0, 0, 0, 0, 9, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 0);
        v(1, 0, 0, 0, 0, 9, 2,  0, 0, 1);
        v(1, 0, 0, 0, 0, 9, 2,  1, 0, 0);

        // max=0: q pinned at 0 with tc on every tick in both directions
        v(1, 0, 0, 0, 0, 0, 0,  1, 0, 1);
        v(1, 0, 0, 0, 0, 0, 0,  0, 1, 1);
        v(1, 0, 0, 1, 0, 0, 0,  0, 1, 1);
        v(1, 0, 0, 1, 0, 0, 0,  0, 1, 1);

        repeat (3) @(posedge clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
